adder_arb_ctrl: RTL

ADDER_ARB_CTRL -- requirements
Module: adder_arb_ctrl

---
 rtl/adder_arb_ctrl_pkg.sv | 12 +
 rtl/adder_arb_ctrl_if.sv | 33 +++
 rtl/adder_arb_ctrl_rr_arb2.sv | 19 +
 rtl/adder_arb_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/adder_arb_ctrl_pkg.sv
// Shared definitions for the arbitrated adder controller: FSM states and default operand width.
package adder_arb_ctrl_pkg;

    localparam int OPW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/adder_arb_ctrl_if.sv
// Request, adder and response signals of the arbitrated adder controller.
// The controller side uses the slave modport; the environment uses the master modport.
interface adder_arb_ctrl_if
    import adder_arb_ctrl_pkg::*;
#(
    parameter int OPW = OPW_DEF
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OPW-1:0]   req0_a;
    logic [OPW-1:0]   req0_b;
    logic [OPW-1:0]   req1_a;
    logic [OPW-1:0]   req1_b;
    logic [2*OPW-1:0] add_opnd;
    logic [2*OPW-1:0] add_sum;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OPW:0]     rsp_sum;
    logic             rsp_id;
    logic             busy;
    logic [7:0]       done_cnt;

    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, add_sum, rsp_ready,
        input  req_ready, add_opnd, rsp_valid, rsp_sum, rsp_id, busy, done_cnt
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, add_sum, rsp_ready,
        output req_ready, add_opnd, rsp_valid, rsp_sum, rsp_id, busy, done_cnt
    );

endinterface

// File: rtl/adder_arb_ctrl_rr_arb2.sv
// Two-way round-robin grant: a sole requester wins; on contention the requester
// that was not served last (ptr_i = index served last) wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/adder_arb_ctrl.sv
// Arbitrates two requesters onto one external adder, one operation in flight,
// and returns the captured sum with the owner's id through a valid/ready response.
module adder_arb_ctrl
    import adder_arb_ctrl_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    adder_arb_ctrl_if.slave bus
);

    state_e           state_q;
    logic [2*OPW-1:0] add_opnd_q;
    logic [OPW:0]     rsp_sum_q;
    logic             rsp_id_q;
    logic             rsp_valid_q;
    logic             ptr_q;
    logic [7:0]       done_cnt_q;

    logic [1:0]       gnt;
    logic             gid;
    logic             accept;
    logic [2*OPW-1:0] opnd_d;
    logic             unused_sum_hi;

    rr_arb2 u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign gid    = gnt[1];
    assign accept = (state_q == IDLE) && (|(bus.req_valid & gnt));
    assign opnd_d = gid ? {bus.req1_a, bus.req1_b} : {bus.req0_a, bus.req0_b};

    // Only the low OPW+1 bits of the adder result carry the sum.
    assign unused_sum_hi = ^bus.add_sum[2*OPW-1:OPW+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            add_opnd_q  <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            ptr_q       <= 1'b1;
            done_cnt_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        add_opnd_q <= opnd_d;
                        rsp_id_q   <= gid;
                        ptr_q      <= gid;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_sum_q   <= bus.add_sum[OPW:0];
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? gnt : 2'b00;
    assign bus.add_opnd  = add_opnd_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done_cnt  = done_cnt_q;

endmodule
